serial_nibble_compare: RTL

- Sequential wide-word magnitude comparator built on the team's 4-bit cascade-compare encoding.
- Takes two operands as a stream of 4-bit nibble pairs, most significant nibble first, under a valid/ready handshake.
- Produces one 3-bit cascade result per word, using the same encoding that the combinational 4-bit comparator's cascade input consumes. The result can drive that comparator's cascade input or a downstream stage.
- Result encoding: 3'b100 = A>B, 3'b010 = A<B, 3'b001 = A=B.

---
 rtl/serial_nibble_compare.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_nibble_compare.sv
// Serial wide-word magnitude comparator: consumes MSB-first nibble pairs and
// emits one 3-bit cascade result (100 A>B, 010 A<B, 001 A=B) per word.
module serial_nibble_compare #(
  parameter int NIBBLES = 4,
  parameter int CW      = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic [3:0]    iData_a,
  input  logic [3:0]    iData_b,
  input  logic [2:0]    iData,
  input  logic          iValid,
  output logic          oReady,
  output logic [2:0]    oData,
  output logic          oValid,
  input  logic          iReady,
  output logic [CW-1:0] oNibbleCnt
);

  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          decided_q, decided_d;
  logic [2:0]    res_q, res_d;
  logic [2:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  logic          cur_dec;
  logic [2:0]    cur_res;

  // Any seed that is not a legal one-hot cascade code degrades to "equal".
  function automatic logic [2:0] clean_seed(input logic [2:0] s);
    case (s)
      3'b100, 3'b010, 3'b001: return s;
      default:                return 3'b001;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    res_d     = res_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    cur_dec   = decided_q;
    cur_res   = res_q;

    case (state_q)
      COLLECT: begin
        if (iValid) begin
          // The first nibble of a word restarts from the seed, undecided.
          if (cnt_q == '0) begin
            cur_dec = 1'b0;
            cur_res = clean_seed(iData);
          end
          if (!cur_dec) begin
            if (iData_a > iData_b) begin
              cur_res = 3'b100;
              cur_dec = 1'b1;
            end else if (iData_a < iData_b) begin
              cur_res = 3'b010;
              cur_dec = 1'b1;
            end
          end
          res_d     = cur_res;
          decided_d = cur_dec;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            data_d  = cur_res;
            valid_d = 1'b1;
            ready_d = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= 3'b001;
      data_q    <= 3'b000;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      res_q     <= res_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign oReady     = ready_q;
  assign oValid     = valid_q;
  assign oData      = data_q;
  assign oNibbleCnt = cnt_q;

endmodule
